// File: rtl/keypad_item_entry.sv
// Keypad front end: turns single-key events into a decimal item number with a one-cycle valid strobe.
// Optional build macro KEYPAD_RANGE_CHECK_EN rejects ENTER of 0 or of values above MAX_ITEM.
module keypad_item_entry #(
    parameter int ITEM_ADDR_WIDTH = 10,
    parameter int MAX_DIGITS      = 3,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MAX_ITEM        = 999
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [3:0]                 key_code,
    input  logic                       key_valid,
    output logic [ITEM_ADDR_WIDTH-1:0] item_select,
    output logic                       item_select_valid,
    output logic                       entry_busy,
    output logic [1:0]                 digit_count,
    output logic                       entry_error
);

    localparam int ACC_W = ITEM_ADDR_WIDTH + 4;
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;
    localparam logic [1:0] DIGIT_LIMIT = 2'(MAX_DIGITS);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ITEM_ADDR_WIDTH-1:0] MAX_ITEM_C = ITEM_ADDR_WIDTH'(MAX_ITEM);
`ifdef KEYPAD_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ENTRY = 1'b1
    } state_t;

    state_t                     state_r;
    logic [ITEM_ADDR_WIDTH-1:0] acc_r;
    logic [TMR_W-1:0]           timer_r;
    logic [ACC_W-1:0]           acc_next_s;
    logic                       is_digit_s;
    logic                       reject_enter_s;

    // Decimal accumulate at widened precision, key classification and ENTER range check.
    always_comb begin
        acc_next_s     = ({4'd0, acc_r} * ACC_W'(4'd10)) + ACC_W'(key_code);
        is_digit_s     = (key_code < KEY_ENTER);
        reject_enter_s = RANGE_CHECK &&
                         ((acc_r > MAX_ITEM_C) || (acc_r == {ITEM_ADDR_WIDTH{1'b0}}));
    end

    // Entry FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r           <= ST_IDLE;
            acc_r             <= {ITEM_ADDR_WIDTH{1'b0}};
            timer_r           <= {TMR_W{1'b0}};
            digit_count       <= 2'd0;
            item_select       <= {ITEM_ADDR_WIDTH{1'b0}};
            item_select_valid <= 1'b0;
            entry_error       <= 1'b0;
            entry_busy        <= 1'b0;
        end else begin
            item_select_valid <= 1'b0;
            entry_error       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    timer_r <= {TMR_W{1'b0}};
                    if (key_valid && is_digit_s) begin
                        acc_r       <= ITEM_ADDR_WIDTH'(key_code);
                        digit_count <= 2'd1;
                        state_r     <= ST_ENTRY;
                        entry_busy  <= 1'b1;
                    end else if (key_valid && (key_code == KEY_ENTER)) begin
                        entry_error <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ENTRY: begin
                    // A key on the timeout edge wins: it is processed and restarts the idle count.
                    if (key_valid) begin
                        timer_r <= {TMR_W{1'b0}};
                        if (is_digit_s) begin
                            if (digit_count >= DIGIT_LIMIT) begin
                                entry_error <= 1'b1;
                            end else begin
                                acc_r       <= acc_next_s[ITEM_ADDR_WIDTH-1:0];
                                digit_count <= digit_count + 2'd1;
                            end
                        end else if ((key_code == KEY_ENTER) || (key_code == KEY_CANCEL)) begin
                            if (key_code == KEY_CANCEL) begin
                                entry_error <= 1'b0;
                            end else if (reject_enter_s) begin
                                entry_error <= 1'b1;
                            end else begin
                                item_select       <= acc_r;
                                item_select_valid <= 1'b1;
                            end
                            acc_r       <= {ITEM_ADDR_WIDTH{1'b0}};
                            digit_count <= 2'd0;
                            state_r     <= ST_IDLE;
                            entry_busy  <= 1'b0;
                        end else begin
                            entry_error <= 1'b1;
                        end
                    end else if (timer_r == TIMER_LAST) begin
                        entry_error <= 1'b1;
                        acc_r       <= {ITEM_ADDR_WIDTH{1'b0}};
                        digit_count <= 2'd0;
                        timer_r     <= {TMR_W{1'b0}};
                        state_r     <= ST_IDLE;
                        entry_busy  <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1'b1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    acc_r       <= {ITEM_ADDR_WIDTH{1'b0}};
                    digit_count <= 2'd0;
                    timer_r     <= {TMR_W{1'b0}};
                    entry_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_item_entry.sv
// Directed self-checking bench for keypad_item_entry (short timeout, MAX_ITEM=500).
module tb_keypad_item_entry;

    localparam int W       = 10;
    localparam int TIMEOUT = 16;

    logic         clk;
    logic         rstn;
    logic [3:0]   key_code;
    logic         key_valid;
    logic [W-1:0] item_select;
    logic         item_select_valid;
    logic         entry_busy;
    logic [1:0]   digit_count;
    logic         entry_error;

    int n_compared;
    int n_mismatched;

    keypad_item_entry #(
        .ITEM_ADDR_WIDTH(W),
        .MAX_DIGITS(3),
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_ITEM(500)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .key_code(key_code),
        .key_valid(key_valid),
        .item_select(item_select),
        .item_select_valid(item_select_valid),
        .entry_busy(entry_busy),
        .digit_count(digit_count),
        .entry_error(entry_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, let the edge sample it, then settle past the edge.
    task automatic cycle(input logic v, input logic [3:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] item, input logic vld,
                              input logic busy, input logic [1:0] dc, input logic err);
        check_value({tag, ".item"},  32'(item_select),       32'(item));
        check_value({tag, ".valid"}, 32'(item_select_valid), 32'(vld));
        check_value({tag, ".busy"},  32'(entry_busy),        32'(busy));
        check_value({tag, ".dc"},    32'(digit_count),       32'(dc));
        check_value({tag, ".err"},   32'(entry_error),       32'(err));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rstn      = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        cycle(1'b0, 4'h0);
        cycle(1'b1, 4'h5);
        check_outs("reset", 10'h000, 1'b0, 1'b0, 2'd0, 1'b0);
        rstn = 1'b1;

        // ENTER from IDLE right after reset
        cycle(1'b1, 4'hA);
        check_outs("idle_enter", 10'h000, 1'b0, 1'b0, 2'd0, 1'b1);
        cycle(1'b0, 4'h0);
        check_value("idle_enter.err_clr", 32'(entry_error), 32'd0);
        cycle(1'b1, 4'hB);
        check_outs("idle_cancel", 10'h000, 1'b0, 1'b0, 2'd0, 1'b0);

        // 1,2,3,ENTER
        cycle(1'b1, 4'h1);
        check_outs("d1", 10'h000, 1'b0, 1'b1, 2'd1, 1'b0);
        cycle(1'b1, 4'h2);
        check_value("d2.dc", 32'(digit_count), 32'd2);
        cycle(1'b1, 4'h3);
        check_value("d3.dc", 32'(digit_count), 32'd3);
        cycle(1'b1, 4'hA);
        check_outs("enter123", 10'h07B, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 4'h0);
        check_outs("hold123", 10'h07B, 1'b0, 1'b0, 2'd0, 1'b0);

        // 4,5,6,7,ENTER: fourth digit dropped with error
        cycle(1'b1, 4'h4);
        cycle(1'b1, 4'h5);
        cycle(1'b1, 4'h6);
        cycle(1'b1, 4'h7);
        check_outs("overflow", 10'h07B, 1'b0, 1'b1, 2'd3, 1'b1);
        cycle(1'b1, 4'hA);
        check_outs("enter456", 10'h1C8, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 4'h0);

        // reserved code mid-entry keeps the entry
        cycle(1'b1, 4'h1);
        cycle(1'b1, 4'hC);
        check_outs("reserved", 10'h1C8, 1'b0, 1'b1, 2'd1, 1'b1);
        cycle(1'b1, 4'hA);
        check_outs("enter1", 10'h001, 1'b1, 1'b0, 2'd0, 1'b0);

        // key 5 then TIMEOUT idle cycles
        cycle(1'b1, 4'h5);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            cycle(1'b0, 4'h0);
            check_value("to_wait.err", 32'(entry_error), 32'd0);
        end
        check_value("to_wait.busy", 32'(entry_busy), 32'd1);
        cycle(1'b0, 4'h0);
        check_outs("timeout", 10'h001, 1'b0, 1'b0, 2'd0, 1'b1);
        cycle(1'b0, 4'h0);
        cycle(1'b1, 4'hA);
        check_outs("to_enter", 10'h001, 1'b0, 1'b0, 2'd0, 1'b1);
        cycle(1'b0, 4'h0);

        // key on the timeout edge wins
        cycle(1'b1, 4'h5);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            cycle(1'b0, 4'h0);
        end
        cycle(1'b1, 4'h6);
        check_outs("to_key", 10'h001, 1'b0, 1'b1, 2'd2, 1'b0);
        cycle(1'b1, 4'hA);
        check_outs("enter56", 10'h038, 1'b1, 1'b0, 2'd0, 1'b0);

        // 8,CANCEL,9,ENTER then 2,ENTER back to back
        cycle(1'b1, 4'h8);
        cycle(1'b1, 4'hB);
        check_outs("cancel", 10'h038, 1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 4'h9);
        cycle(1'b1, 4'hA);
        check_outs("enter9", 10'h009, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 4'h2);
        check_outs("b2b_d2", 10'h009, 1'b0, 1'b1, 2'd1, 1'b0);
        cycle(1'b1, 4'hA);
        check_outs("enter2", 10'h002, 1'b1, 1'b0, 2'd0, 1'b0);

        // leading zeros
        cycle(1'b1, 4'h0);
        cycle(1'b1, 4'h0);
        cycle(1'b1, 4'h7);
        cycle(1'b1, 4'hA);
        check_outs("enter007", 10'h007, 1'b1, 1'b0, 2'd0, 1'b0);

        // reset mid-entry
        cycle(1'b1, 4'h3);
        cycle(1'b1, 4'h1);
        rstn = 1'b0;
        cycle(1'b0, 4'h0);
        check_outs("mid_reset", 10'h000, 1'b0, 1'b0, 2'd0, 1'b0);
        rstn = 1'b1;
        cycle(1'b1, 4'hA);
        check_outs("post_reset_enter", 10'h000, 1'b0, 1'b0, 2'd0, 1'b1);

        // 6,0,0,ENTER against MAX_ITEM=500
        cycle(1'b1, 4'h6);
        cycle(1'b1, 4'h0);
        cycle(1'b1, 4'h0);
        cycle(1'b1, 4'hA);
`ifdef KEYPAD_RANGE_CHECK_EN
        check_outs("enter600", 10'h000, 1'b0, 1'b0, 2'd0, 1'b1);
`else
        check_outs("enter600", 10'h258, 1'b1, 1'b0, 2'd0, 1'b0);
`endif
        cycle(1'b0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_item_entry.md
Name: keypad_item_entry

Overview:
Front-end producer for the item selection path. It converts a stream of single-key events from the vending keypad into a decimal item number. It presents that number as item_select with a one-cycle item_select_valid strobe, which is the input handshake consumed by the item_select block. It handles digit accumulation, ENTER, CANCEL, overflow of digit count and inactivity timeout.

Parameters:
ITEM_ADDR_WIDTH, 10, width of item_select; must hold 10^MAX_DIGITS-1
MAX_DIGITS, 3, maximum decimal digits per entry (1..3 supported)
TIMEOUT_CYCLES, 1000, idle clock cycles in ENTRY before the entry is discarded (>=2)
MAX_ITEM, 999, highest legal item number (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
key_code  input  4  key event: 0-9 digit, 4'hA ENTER, 4'hB CANCEL, 4'hC-4'hF reserved
key_valid  input  1  key_code valid this cycle; one key event per high cycle
item_select  output  ITEM_ADDR_WIDTH  registered item number, held between strobes
item_select_valid  output  1  one-cycle strobe, item_select valid
entry_busy  output  1  high while in ENTRY state
digit_count  output  2  digits accumulated in current entry
entry_error  output  1  one-cycle pulse on rejected or aborted entry

Behaviour:
- Interface (decided): single clock clk; reset rstn synchronous, active-low.
- Reset (rstn=0 at a rising edge) forces the following, regardless of state: state=IDLE, accumulator=0, digit_count=0, timeout counter=0, item_select=0, item_select_valid=0, entry_error=0, entry_busy=0.
- States:
  - IDLE: no entry in progress.
  - ENTRY: at least one digit held.
- Accumulator rule: acc_next = acc*10 + digit. Compute at ITEM_ADDR_WIDTH+4 bits and truncate to ITEM_ADDR_WIDTH. No overflow is possible within MAX_DIGITS.
- IDLE:
  - Digit: acc=digit, digit_count=1, go to ENTRY.
  - ENTER: entry_error pulse next cycle, stay in IDLE.
  - CANCEL and reserved codes: ignored, no error.
- ENTRY, on key_valid:
  - Digit with digit_count<MAX_DIGITS: accumulate, digit_count+1.
  - Digit with digit_count==MAX_DIGITS: digit dropped, entry_error pulse, stay in ENTRY.
  - ENTER: item_select<=acc, item_select_valid=1 for exactly one cycle, then clear acc and digit_count and go to IDLE.
  - CANCEL: clear acc and digit_count, go to IDLE, no error, no strobe.
  - Reserved code: entry_error pulse, entry kept.
- Latency: ENTER sampled at edge N gives item_select and item_select_valid high in the cycle after edge N. A digit sampled at edge N+1 starts a new entry without loss.
- Timeout:
  - The counter is cleared by every key_valid and increments each ENTRY cycle without key_valid.
  - When it reaches TIMEOUT_CYCLES-1, the next edge discards the entry, pulses entry_error and goes to IDLE.
  - A key arriving on that same edge takes priority: the key is processed and the timeout is cancelled.
- item_select holds its last value indefinitely; only an accepted ENTER updates it.
- Leading zeros count as digits: 0,0,7,ENTER yields 7.
- entry_error and item_select_valid are never both high in the same cycle.

Optional Feature:
KEYPAD_RANGE_CHECK_EN
- Defined: on ENTER, if acc>MAX_ITEM or acc==0, no strobe is issued; entry_error pulses instead and the state returns to IDLE with the entry cleared.
- Undefined: any accumulated value, including 0, is strobed out and MAX_ITEM is unused.

Test Plan:
1. Keys 1,2,3,ENTER, one per cycle -> item_select=10'h07B, item_select_valid high exactly one cycle after ENTER, digit_count back to 0, entry_busy low.
2. ENTER from IDLE after reset -> entry_error one-cycle pulse, item_select_valid stays 0, item_select stays 10'h000.
3. Keys 4,5,6,7,ENTER -> entry_error pulse one cycle after key 7; item_select=10'h1C8 (456) strobed once.
4. Key 5, then no keys for TIMEOUT_CYCLES cycles -> entry_error pulse, state IDLE, digit_count=0. A following ENTER gives another error and no strobe.
5. Keys 8,CANCEL,9,ENTER -> no error and no strobe on CANCEL; item_select=10'h009 strobed. Then key 2 on the cycle right after the strobe, followed by ENTER -> item_select=10'h002.
6. Keys 3,1, then rstn=0 for one edge mid-entry -> all outputs 0, digit_count=0. After release, ENTER gives entry_error only. With KEYPAD_RANGE_CHECK_EN defined and MAX_ITEM=500, keys 6,0,0,ENTER -> entry_error, no strobe.
